imm_gen_sequencer: RTL

//  Front-end controller for the registered immediate generator. Accepts one 32-bit

---
 rtl/imm_gen_sequencer_if.sv | 30 +++
 rtl/imm_gen_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/imm_gen_sequencer_if.sv
// Bus between the immediate-generator sequencer and its surroundings:
// the instruction intake, the generator operand/result fields, and the result output.
interface imm_gen_sequencer_if;
  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
  // A source holding valid keeps its payload stable until that edge. A sink may drop
  // ready at any time. Neither side waits on the other's signal combinationally.
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic [2:0]  immsrc;
  logic [19:0] inx20;
  logic [11:0] inx12;
  logic [31:0] imm_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm_value;
  logic [2:0]  imm_type;
  logic        err;

  modport slave (
    input  in_valid, instr, flush, imm_in, out_ready,
    output in_ready, immsrc, inx20, inx12, out_valid, imm_value, imm_type, err
  );

  modport master (
    output in_valid, instr, flush, imm_in, out_ready,
    input  in_ready, immsrc, inx20, inx12, out_valid, imm_value, imm_type, err
  );
endinterface

// File: rtl/imm_gen_sequencer.sv
// Front-end controller for the registered immediate generator: decodes an instruction,
// drives the generator fields for IMM_LAT edges, captures the result and hands it on.
module imm_gen_sequencer #(
  parameter int IMM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  imm_gen_sequencer_if.slave bus,
  output logic [1:0]         state_o
);

  localparam int CNT_W = (IMM_LAT < 2) ? 1 : $clog2(IMM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       immsrc_q, immsrc_d;
  logic [19:0]      inx20_q, inx20_d;
  logic [11:0]      inx12_q, inx12_d;
  logic [31:0]      imm_value_q, imm_value_d;
  logic [2:0]       imm_type_q, imm_type_d;
  logic             err_q, err_d;

  logic             dec_legal;
  logic [2:0]       dec_src;
  logic [11:0]      dec_inx12;

  // Opcode to generator format; funct3 001/101 of OP-IMM are shifts (5-bit shamt).
  always_comb begin
    dec_legal = 1'b1;
    dec_src   = 3'd0;
    case (bus.instr[6:0])
      7'b0110111, 7'b0010111: dec_src = 3'd0;
      7'b1101111:             dec_src = 3'd1;
      7'b0000011, 7'b1100111: dec_src = 3'd4;
      7'b0100011:             dec_src = 3'd5;
      7'b1100011:             dec_src = 3'd6;
      7'b0010011: begin
        if (bus.instr[14:12] == 3'b001 || bus.instr[14:12] == 3'b101) begin
          dec_src = 3'd3;
        end else begin
          dec_src = 3'd2;
        end
      end
      default:                dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    dec_inx12 = 12'd0;
    case (dec_src)
      3'd2, 3'd3, 3'd4: dec_inx12 = bus.instr[31:20];
      3'd5:             dec_inx12 = {bus.instr[31:25], bus.instr[11:7]};
      3'd6:             dec_inx12 = {bus.instr[31], bus.instr[30:25], bus.instr[11:8], bus.instr[7]};
      default:          dec_inx12 = 12'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    immsrc_d    = immsrc_q;
    inx20_d     = inx20_q;
    inx12_d     = inx12_q;
    imm_value_d = imm_value_q;
    imm_type_d  = imm_type_q;
    err_d       = err_q;
    if (bus.flush) begin
      // Abort wins over any accept; generator fields stay as they were.
      state_d = IDLE;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (dec_legal) begin
              immsrc_d = dec_src;
              inx20_d  = bus.instr[31:12];
              inx12_d  = dec_inx12;
              cnt_d    = CNT_W'(IMM_LAT);
              state_d  = GEN;
            end else begin
              imm_value_d = 32'd0;
              imm_type_d  = 3'd0;
              err_d       = 1'b1;
              state_d     = HOLD;
            end
          end
        end
        GEN: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = CAPT;
          end
        end
        CAPT: begin
          imm_value_d = bus.imm_in;
          imm_type_d  = immsrc_q;
          err_d       = 1'b0;
          state_d     = HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      immsrc_q    <= 3'd0;
      inx20_q     <= 20'd0;
      inx12_q     <= 12'd0;
      imm_value_q <= 32'd0;
      imm_type_q  <= 3'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      immsrc_q    <= immsrc_d;
      inx20_q     <= inx20_d;
      inx12_q     <= inx12_d;
      imm_value_q <= imm_value_d;
      imm_type_q  <= imm_type_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.immsrc    = immsrc_q;
  assign bus.inx20     = inx20_q;
  assign bus.inx12     = inx12_q;
  assign bus.imm_value = imm_value_q;
  assign bus.imm_type  = imm_type_q;
  assign bus.err       = err_q;
  assign state_o       = state_q;

endmodule
